// File: rtl/vx_dispatch_batched_if.sv
// Issue-slot dispatch bus: one operand packet in, NUM_EX beat channels out.
// The master drives packets and per-channel accepts; the slave is the dispatcher.
interface vx_dispatch_batched_if #(
    parameter int unsigned NUM_EX     = 4,
    parameter int unsigned THREAD_CNT = 4,
    parameter int unsigned LANE_CNT   = 4,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HDR_W      = 64
);
    localparam int unsigned EXW  = (NUM_EX > 1) ? $clog2(NUM_EX) : 1;
    localparam int unsigned NB   = THREAD_CNT / LANE_CNT;
    localparam int unsigned PIDW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TIDW = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1;

    logic                              in_valid;
    logic                              in_ready;
    logic [EXW-1:0]                    in_ex;
    logic [HDR_W-1:0]                  in_hdr;
    logic [THREAD_CNT-1:0]             in_tmask;
    logic [THREAD_CNT*XLEN-1:0]        in_rs1;
    logic [THREAD_CNT*XLEN-1:0]        in_rs2;
    logic [THREAD_CNT*XLEN-1:0]        in_rs3;

    logic [NUM_EX-1:0]                 out_valid;
    logic [NUM_EX-1:0]                 out_ready;
    logic [NUM_EX*HDR_W-1:0]           out_hdr;
    logic [NUM_EX*LANE_CNT-1:0]        out_tmask;
    logic [NUM_EX*LANE_CNT*XLEN-1:0]   out_rs1;
    logic [NUM_EX*LANE_CNT*XLEN-1:0]   out_rs2;
    logic [NUM_EX*LANE_CNT*XLEN-1:0]   out_rs3;
    logic [NUM_EX*PIDW-1:0]            out_pid;
    logic [NUM_EX-1:0]                 out_sop;
    logic [NUM_EX-1:0]                 out_eop;
    logic [NUM_EX*TIDW-1:0]            out_ltid;

    modport master (
        output in_valid, in_ex, in_hdr, in_tmask, in_rs1, in_rs2, in_rs3, out_ready,
        input  in_ready, out_valid, out_hdr, out_tmask, out_rs1, out_rs2, out_rs3,
               out_pid, out_sop, out_eop, out_ltid
    );

    modport slave (
        input  in_valid, in_ex, in_hdr, in_tmask, in_rs1, in_rs2, in_rs3, out_ready,
        output in_ready, out_valid, out_hdr, out_tmask, out_rs1, out_rs2, out_rs3,
               out_pid, out_sop, out_eop, out_ltid
    );
endinterface

// File: rtl/vx_dispatch_batched.sv
// Per-issue-slot dispatcher: splits a THREAD_CNT-wide packet into active LANE_CNT-wide
// beats and queues them on one of NUM_EX execution-unit channels.
module vx_dispatch_batched #(
    parameter int unsigned NUM_EX     = 4,
    parameter int unsigned THREAD_CNT = 4,
    parameter int unsigned LANE_CNT   = 4,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HDR_W      = 64,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CTR_W      = 44
) (
    input  logic                      clk,
    input  logic                      reset,
    vx_dispatch_batched_if.slave      bus,
    output logic [NUM_EX*CTR_W-1:0]   stalls
);
    localparam int unsigned EXW    = (NUM_EX > 1) ? $clog2(NUM_EX) : 1;
    localparam int unsigned NB     = THREAD_CNT / LANE_CNT;
    localparam int unsigned PIDW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TIDW   = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1;
    localparam int unsigned BEAT_W = LANE_CNT * XLEN;

    typedef struct packed {
        logic [HDR_W-1:0]    hdr;
        logic [LANE_CNT-1:0] tmask;
        logic [BEAT_W-1:0]   rs1;
        logic [BEAT_W-1:0]   rs2;
        logic [BEAT_W-1:0]   rs3;
        logic [PIDW-1:0]     pid;
        logic                sop;
        logic                eop;
        logic [TIDW-1:0]     ltid;
    } beat_t;

    logic [PIDW-1:0]   pid_r;
    logic              sop_pending;
    logic [EXW-1:0]    ex_r;

    logic [NB-1:0]     beat_act;
    logic [PIDW-1:0]   sel;
    logic              sel_eop;
    logic [TIDW-1:0]   ltid;
    beat_t             beat;
    logic              ex_ok;
    logic              push;

    logic [NUM_EX-1:0] pop;
    logic [NUM_EX-1:0] blk;
    logic [DEPTH-1:0]  vld     [NUM_EX];
    logic [DEPTH-1:0]  vld_nxt [NUM_EX];
    beat_t             q       [NUM_EX][DEPTH];
    beat_t             q_nxt   [NUM_EX][DEPTH];
    logic [CTR_W-1:0]  stall_r [NUM_EX];

    // Splitter: lowest active beat at/after pid_r; an all-zero mask still yields beat 0 as eop.
    always_comb begin
        for (int unsigned b = 0; b < NB; b++) begin
            beat_act[b] = |bus.in_tmask[b*LANE_CNT +: LANE_CNT];
        end
        sel = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (b >= int'(pid_r) && beat_act[b]) sel = PIDW'(b);
        end
        sel_eop = 1'b1;
        for (int b = 0; b < NB; b++) begin
            if (b > int'(sel) && beat_act[b]) sel_eop = 1'b0;
        end
        ltid = '0;
        for (int t = 0; t < THREAD_CNT; t++) begin
            if (bus.in_tmask[t]) ltid = TIDW'(t);
        end
    end

    always_comb begin
        beat.hdr   = bus.in_hdr;
        beat.tmask = bus.in_tmask[32'(sel)*LANE_CNT +: LANE_CNT];
        beat.rs1   = bus.in_rs1[32'(sel)*BEAT_W +: BEAT_W];
        beat.rs2   = bus.in_rs2[32'(sel)*BEAT_W +: BEAT_W];
        beat.rs3   = bus.in_rs3[32'(sel)*BEAT_W +: BEAT_W];
        beat.pid   = sel;
        beat.sop   = sop_pending;
        beat.eop   = sel_eop;
        beat.ltid  = ltid;
    end

    // A full queue still takes a beat when its head leaves in the same cycle.
    always_comb begin
        for (int unsigned e = 0; e < NUM_EX; e++) begin
            pop[e] = vld[e][0] && bus.out_ready[e];
            blk[e] = vld[e][DEPTH-1] && !pop[e];
        end
        ex_ok = 32'(bus.in_ex) < NUM_EX;
        push  = bus.in_valid && !reset && ex_ok && !blk[bus.in_ex];
    end

    assign bus.in_ready = push && sel_eop;

    // Shift-register queues: slot 0 is always the head, so outputs come straight off flops.
    always_comb begin
        logic placed;
        placed  = 1'b0;
        q_nxt   = q;
        vld_nxt = vld;
        for (int unsigned e = 0; e < NUM_EX; e++) begin
            if (pop[e]) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    q_nxt[e][i]   = q[e][i+1];
                    vld_nxt[e][i] = vld[e][i+1];
                end
                vld_nxt[e][DEPTH-1] = 1'b0;
            end
            placed = 1'b0;
            if (push && 32'(bus.in_ex) == e) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (!placed && !vld_nxt[e][i]) begin
                        q_nxt[e][i]   = beat;
                        vld_nxt[e][i] = 1'b1;
                        placed        = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pid_r       <= '0;
            sop_pending <= 1'b1;
            ex_r        <= '0;
            for (int unsigned e = 0; e < NUM_EX; e++) begin
                vld[e]     <= '0;
                stall_r[e] <= '0;
            end
        end else begin
            if (push) begin
                ex_r <= bus.in_ex;
                if (sel_eop) begin
                    pid_r       <= '0;
                    sop_pending <= 1'b1;
                end else begin
                    pid_r       <= PIDW'(32'(sel) + 32'd1);
                    sop_pending <= 1'b0;
                end
            end
            for (int unsigned e = 0; e < NUM_EX; e++) begin
                vld[e] <= vld_nxt[e];
                if (bus.in_valid && 32'(bus.in_ex) == e && blk[e] && stall_r[e] != '1) begin
                    stall_r[e] <= stall_r[e] + 1'b1;
                end
            end
        end
    end

    // Payload flops carry no reset; they are qualified by vld.
    always_ff @(posedge clk) begin
        q <= q_nxt;
    end

    for (genvar e = 0; e < NUM_EX; e++) begin : g_out
        assign bus.out_valid[e]                    = vld[e][0];
        assign bus.out_hdr[e*HDR_W +: HDR_W]       = q[e][0].hdr;
        assign bus.out_tmask[e*LANE_CNT +: LANE_CNT] = q[e][0].tmask;
        assign bus.out_rs1[e*BEAT_W +: BEAT_W]     = q[e][0].rs1;
        assign bus.out_rs2[e*BEAT_W +: BEAT_W]     = q[e][0].rs2;
        assign bus.out_rs3[e*BEAT_W +: BEAT_W]     = q[e][0].rs3;
        assign bus.out_pid[e*PIDW +: PIDW]         = q[e][0].pid;
        assign bus.out_sop[e]                      = q[e][0].sop;
        assign bus.out_eop[e]                      = q[e][0].eop;
        assign bus.out_ltid[e*TIDW +: TIDW]        = q[e][0].ltid;
        assign stalls[e*CTR_W +: CTR_W]            = stall_r[e];
    end

    a_ex_range: assert property (@(posedge clk) disable iff (reset)
        bus.in_valid |-> ex_ok);

    a_ex_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.in_valid && !sop_pending) |-> (bus.in_ex == ex_r));

endmodule

// File: tb/tb_vx_dispatch_batched.sv
// Bench for vx_dispatch_batched: directed vector table, corner sequences and random
// traffic, all scored against a queue-level model of beats per channel.
module tb_vx_dispatch_batched;
    localparam int unsigned NUM_EX     = 4;
    localparam int unsigned THREAD_CNT = 8;
    localparam int unsigned LANE_CNT   = 2;
    localparam int unsigned XLEN       = 16;
    localparam int unsigned HDR_W      = 16;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned CTR_W      = 4;
    localparam int unsigned NB         = THREAD_CNT / LANE_CNT;
    localparam int unsigned PIDW       = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TIDW       = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1;
    localparam int unsigned BW         = LANE_CNT * XLEN;
    localparam int unsigned SMAX       = (1 << CTR_W) - 1;

    typedef struct packed {
        logic [HDR_W-1:0]    hdr;
        logic [LANE_CNT-1:0] tmask;
        logic [BW-1:0]       rs1;
        logic [BW-1:0]       rs2;
        logic [BW-1:0]       rs3;
        logic [PIDW-1:0]     pid;
        logic                sop;
        logic                eop;
        logic [TIDW-1:0]     ltid;
    } beat_t;

    typedef struct {
        logic [1:0] ex;
        logic [7:0] tmask;
        int         n;
        int         first_pid;
        int         last_pid;
        int         ltid;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [NUM_EX*CTR_W-1:0] stalls;

    vx_dispatch_batched_if #(.NUM_EX(NUM_EX), .THREAD_CNT(THREAD_CNT), .LANE_CNT(LANE_CNT),
                             .XLEN(XLEN), .HDR_W(HDR_W)) bus ();

    vx_dispatch_batched #(.NUM_EX(NUM_EX), .THREAD_CNT(THREAD_CNT), .LANE_CNT(LANE_CNT),
                          .XLEN(XLEN), .HDR_W(HDR_W), .DEPTH(DEPTH), .CTR_W(CTR_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .stalls (stalls)
    );

    always #5 clk = ~clk;

    beat_t       mq [NUM_EX][$];
    beat_t       pbeats[$];
    beat_t       seen[$];
    int          seen_ch[$];
    int          pidx;
    bit          accepted;
    bit          rnd_ready;
    int unsigned mstall [NUM_EX];
    int          n_pass;
    int          n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic beat_t mk(int b, int hi, bit s, bit e);
        beat_t r;
        r.hdr   = bus.in_hdr;
        r.tmask = bus.in_tmask[b*LANE_CNT +: LANE_CNT];
        r.rs1   = bus.in_rs1[b*BW +: BW];
        r.rs2   = bus.in_rs2[b*BW +: BW];
        r.rs3   = bus.in_rs3[b*BW +: BW];
        r.pid   = PIDW'(b);
        r.sop   = s;
        r.eop   = e;
        r.ltid  = TIDW'(hi);
        return r;
    endfunction

    // Expected beat list straight from the packet: every non-empty lane group, or beat 0 alone.
    function automatic void build_beats();
        int act[$];
        int hi;
        hi = 0;
        pbeats.delete();
        for (int t = 0; t < THREAD_CNT; t++) if (bus.in_tmask[t]) hi = t;
        for (int b = 0; b < NB; b++) if (bus.in_tmask[b*LANE_CNT +: LANE_CNT] != '0) act.push_back(b);
        if (act.size() == 0) act.push_back(0);
        foreach (act[k]) pbeats.push_back(mk(act[k], hi, k == 0, k == act.size() - 1));
        pidx = 0;
    endfunction

    function automatic beat_t get_out(int i);
        beat_t r;
        r.hdr   = bus.out_hdr[i*HDR_W +: HDR_W];
        r.tmask = bus.out_tmask[i*LANE_CNT +: LANE_CNT];
        r.rs1   = bus.out_rs1[i*BW +: BW];
        r.rs2   = bus.out_rs2[i*BW +: BW];
        r.rs3   = bus.out_rs3[i*BW +: BW];
        r.pid   = bus.out_pid[i*PIDW +: PIDW];
        r.sop   = bus.out_sop[i];
        r.eop   = bus.out_eop[i];
        r.ltid  = bus.out_ltid[i*TIDW +: TIDW];
        return r;
    endfunction

    // One clock: compare DUT to model just after the negedge, then advance the model at posedge.
    task automatic step();
        beat_t f;
        beat_t a;
        bit    push;
        bit    blocked;
        bit    pop_e;
        int    e;
        if (rnd_ready) for (int i = 0; i < NUM_EX; i++) bus.out_ready[i] = ($urandom_range(0, 9) < 7);
        #1;
        for (int i = 0; i < NUM_EX; i++) begin
            chk("out_valid", 64'(bus.out_valid[i]), 64'(mq[i].size() > 0));
            if (mq[i].size() > 0) begin
                f = mq[i][0];
                a = get_out(i);
                chk("out_hdr",   64'(a.hdr),   64'(f.hdr));
                chk("out_tmask", 64'(a.tmask), 64'(f.tmask));
                chk("out_rs1",   64'(a.rs1),   64'(f.rs1));
                chk("out_rs2",   64'(a.rs2),   64'(f.rs2));
                chk("out_rs3",   64'(a.rs3),   64'(f.rs3));
                chk("out_pid",   64'(a.pid),   64'(f.pid));
                chk("out_sop",   64'(a.sop),   64'(f.sop));
                chk("out_eop",   64'(a.eop),   64'(f.eop));
                chk("out_ltid",  64'(a.ltid),  64'(f.ltid));
            end
            if (bus.out_valid[i] && bus.out_ready[i]) begin
                seen.push_back(get_out(i));
                seen_ch.push_back(i);
            end
            chk("stalls", 64'(stalls[i*CTR_W +: CTR_W]), 64'(mstall[i]));
        end
        push = 1'b0;
        blocked = 1'b0;
        e = int'(bus.in_ex);
        if (bus.in_valid && !reset) begin
            pop_e = mq[e].size() > 0 && bus.out_ready[e];
            if (mq[e].size() < DEPTH || pop_e) push = 1'b1;
            else blocked = 1'b1;
        end
        chk("in_ready", 64'(bus.in_ready), 64'(push && pidx == pbeats.size() - 1));
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NUM_EX; i++) begin
                mq[i].delete();
                mstall[i] = 0;
            end
            pidx = 0;
        end else begin
            for (int i = 0; i < NUM_EX; i++)
                if (mq[i].size() > 0 && bus.out_ready[i]) void'(mq[i].pop_front());
            if (push) begin
                mq[e].push_back(pbeats[pidx]);
                if (pidx == pbeats.size() - 1) begin
                    pidx = 0;
                    accepted = 1'b1;
                end else pidx++;
            end
            if (blocked && mstall[e] < SMAX) mstall[e]++;
        end
        @(negedge clk);
    endtask

    task automatic start_pkt(input logic [1:0] ex, input logic [7:0] tm, input logic [15:0] hdr);
        bus.in_ex    = ex;
        bus.in_tmask = tm;
        bus.in_hdr   = hdr;
        bus.in_rs1   = {$urandom, $urandom, $urandom, $urandom};
        bus.in_rs2   = {$urandom, $urandom, $urandom, $urandom};
        bus.in_rs3   = {$urandom, $urandom, $urandom, $urandom};
        bus.in_valid = 1'b1;
        accepted     = 1'b0;
        build_beats();
    endtask

    task automatic wait_acc(output int cyc);
        cyc = 0;
        while (!accepted && cyc < 200) begin
            step();
            cyc++;
        end
        if (!accepted) begin
            n_total++;
            $display("FAIL accept_timeout: packet not taken after %0d cycles, expected acceptance", cyc);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [1:0] ex, input logic [7:0] tm, input logic [15:0] hdr,
                            output int cyc);
        start_pkt(ex, tm, hdr);
        wait_acc(cyc);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   cyc;
        int   c2;
        logic [7:0] tm;

        tbl[0] = '{2'd0, 8'b1100_0011, 2, 0, 3, 7};
        tbl[1] = '{2'd1, 8'b0000_0000, 1, 0, 0, 0};
        tbl[2] = '{2'd2, 8'b1111_1111, 4, 0, 3, 7};
        tbl[3] = '{2'd3, 8'b0000_0100, 1, 1, 1, 2};
        tbl[4] = '{2'd0, 8'b0101_0000, 2, 2, 3, 6};
        tbl[5] = '{2'd3, 8'b0010_1000, 2, 1, 2, 5};
        tbl[6] = '{2'd1, 8'b1000_0000, 1, 3, 3, 7};
        tbl[7] = '{2'd2, 8'b0000_0001, 1, 0, 0, 0};

        n_pass = 0;
        n_total = 0;
        rnd_ready = 1'b0;
        pidx = 0;
        accepted = 1'b0;
        for (int i = 0; i < NUM_EX; i++) mstall[i] = 0;
        bus.in_valid = 1'b0; bus.in_ex = '0; bus.in_hdr = '0; bus.in_tmask = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rs3 = '0; bus.out_ready = '0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // Reset state, with a packet offered: nothing may be taken while reset is high.
        start_pkt(2'd0, 8'h00, 16'h0);
        step();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        step();

        // Directed table on idle, always-ready channels.
        bus.out_ready = '1;
        for (int k = 0; k < 8; k++) begin
            seen.delete();
            seen_ch.delete();
            send_pkt(tbl[k].ex, tbl[k].tmask, 16'(16'h1000 + k), cyc);
            idle(3);
            chk("tbl_accept_cycles", 64'(cyc), 64'(tbl[k].n));
            chk("tbl_nbeats", 64'(seen.size()), 64'(tbl[k].n));
            if (seen.size() > 0) begin
                chk("tbl_channel",  64'(seen_ch[0]), 64'(tbl[k].ex));
                chk("tbl_first_pid", 64'(seen[0].pid), 64'(tbl[k].first_pid));
                chk("tbl_last_pid", 64'(seen[seen.size()-1].pid), 64'(tbl[k].last_pid));
                chk("tbl_sop", 64'(seen[0].sop), 64'd1);
                chk("tbl_eop", 64'(seen[seen.size()-1].eop), 64'd1);
                chk("tbl_ltid", 64'(seen[0].ltid), 64'(tbl[k].ltid));
            end
        end

        // Back-pressure on ex1: two packets fit, the third waits and the stall counter saturates.
        seen.delete();
        seen_ch.delete();
        bus.out_ready = 4'b1101;
        for (int p = 0; p < 2; p++) begin
            send_pkt(2'd1, 8'h01, 16'(16'h4000 + p), cyc);
            chk("t4_fill_cycles", 64'(cyc), 64'd1);
        end
        start_pkt(2'd1, 8'h01, 16'h4002);
        repeat (3) step();
        chk("t4_stall3", 64'(stalls[1*CTR_W +: CTR_W]), 64'd3);
        chk("t4_in_ready_low", 64'(bus.in_ready), 64'd0);
        repeat (17) step();
        chk("t4_stall_sat", 64'(stalls[1*CTR_W +: CTR_W]), 64'(SMAX));
        bus.out_ready[1] = 1'b1;
        wait_acc(cyc);
        for (int p = 3; p < 5; p++) send_pkt(2'd1, 8'h01, 16'(16'h4000 + p), cyc);
        idle(4);
        chk("t4_count", 64'(seen.size()), 64'd5);
        for (int k = 0; k < 5 && k < seen.size(); k++)
            chk("t4_order", 64'(seen[k].hdr), 64'(16'h4000 + k));

        // Back-to-back packets to ex0 then ex2 with no gap between them.
        seen.delete();
        seen_ch.delete();
        bus.out_ready = '1;
        start_pkt(2'd0, 8'b0011_0011, 16'hA000);
        wait_acc(cyc);
        start_pkt(2'd2, 8'b1000_0100, 16'hB000);
        wait_acc(c2);
        idle(3);
        chk("t5_cycles_a", 64'(cyc), 64'd2);
        chk("t5_cycles_b", 64'(c2), 64'd2);
        chk("t5_count", 64'(seen.size()), 64'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++) begin
            chk("t5_channel", 64'(seen_ch[k]), (k < 2) ? 64'd0 : 64'd2);
            chk("t5_hdr", 64'(seen[k].hdr), (k < 2) ? 64'hA000 : 64'hB000);
        end

        // Reset after the first beat of a two-beat packet, then re-present it.
        bus.out_ready = 4'b1110;
        start_pkt(2'd0, 8'b1100_0011, 16'hC000);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = '1;
        seen.delete();
        seen_ch.delete();
        start_pkt(2'd0, 8'b1100_0011, 16'hC001);
        wait_acc(cyc);
        idle(3);
        chk("t6_count", 64'(seen.size()), 64'd2);
        if (seen.size() == 2) begin
            chk("t6_sop", 64'(seen[0].sop), 64'd1);
            chk("t6_pid0", 64'(seen[0].pid), 64'd0);
            chk("t6_pid1", 64'(seen[1].pid), 64'd3);
        end

        // Random traffic with random per-channel back-pressure.
        rnd_ready = 1'b1;
        for (int p = 0; p < 300; p++) begin
            idle($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       tm = 8'h00;
                1:       tm = 8'(1 << $urandom_range(0, 7));
                default: tm = 8'($urandom);
            endcase
            send_pkt(2'($urandom_range(0, NUM_EX - 1)), tm, 16'($urandom), cyc);
        end
        rnd_ready = 1'b0;
        bus.out_ready = '1;
        idle(8);
        chk("drain_empty", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
